// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: FWFT receive FIFO for SPI words with occupancy, almost-full and sticky error flags.
module spi_rx_fifo #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH_LOG2  = 3,
    parameter int AFULL_LEVEL = 6
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AFULL_C = (DEPTH_LOG2+1)'(AFULL_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_ovf, r_udf;
    logic                  w_empty, w_full, w_rd_acc, w_wr_acc;

    assign w_empty  = r_count == '0;
    assign w_full   = r_count == DEPTH_C;
    // flush discards same-cycle traffic, so both accepts are gated by it
    assign w_rd_acc = ~flush & rd_en & ~w_empty;
    assign w_wr_acc = ~flush & wr_en & (~w_full | w_rd_acc);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(w_wr_acc);
            r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(w_rd_acc);
            r_count  <= r_count + (DEPTH_LOG2+1)'(w_wr_acc) - (DEPTH_LOG2+1)'(w_rd_acc);
            r_ovf    <= r_ovf | (wr_en & w_full & ~w_rd_acc);
            r_udf    <= r_udf | (rd_en & w_empty);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wr_ptr] <= wr_data;
    end

    assign rd_data     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = r_count >= AFULL_C;
    assign count       = r_count;
    assign overflow    = r_ovf;
    assign underflow   = r_udf;
endmodule

// File: tb/tb_spi_rx_fifo.sv
// tb_spi_rx_fifo: directed plan plus random traffic checked against a queue-based reference model.
module tb_spi_rx_fifo;
    logic        clk = 1'b0, reset_b = 1'b0, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [15:0] wr_data = '0, rd_data;
    logic        empty, full, almost_full, overflow, underflow;
    logic [3:0]  count;

    spi_rx_fifo dut (
        .clk(clk), .reset_b(reset_b), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
        .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_bad = 0;
    logic [15:0] q[$];
    bit          m_ovf = 0, m_udf = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == 8));
        chk({tag, ".afull"}, 32'(almost_full), 32'(q.size() >= 6));
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".data"}, 32'(rd_data), 32'(q.size() > 0 ? q[0] : 16'h0));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".udf"}, 32'(underflow), 32'(m_udf));
    endtask

    // one clock: drive, update the model at the edge, then compare just after it
    task automatic step(input bit w, input logic [15:0] d, input bit r, input bit f, input string tag);
        int n;
        bit ra;
        wr_en = w; wr_data = d; rd_en = r; flush = f;
        @(posedge clk);
        n = q.size();
        if (f) begin
            q.delete(); m_ovf = 0; m_udf = 0;
        end else begin
            ra = r && n > 0;
            if (r && n == 0) m_udf = 1;
            if (ra) void'(q.pop_front());
            if (w) begin
                if (n < 8 || ra) q.push_back(d);
                else m_ovf = 1;
            end
        end
        #1;
        wr_en = 0; rd_en = 0; flush = 0;
        check_all(tag);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.data0", 32'(rd_data), 32'h0);
        @(negedge clk) reset_b = 1'b1;

        step(1, 16'hA001, 0, 0, "tp1_wr");
        chk("tp1_head", 32'(rd_data), 32'hA001);
        step(0, 16'h0, 1, 0, "tp1_rd");
        chk("tp1_empty", 32'(empty), 32'h1);

        for (int i = 1; i <= 9; i++) begin
            step(1, 16'(i), 0, 0, "tp2_wr");
            if (i == 6) chk("tp2_afull", 32'(almost_full), 32'h1);
            if (i == 8) chk("tp2_full", 32'(full), 32'h1);
        end
        chk("tp2_ovf", 32'(overflow), 32'h1);
        for (int i = 1; i <= 8; i++) begin
            chk("tp2_order", 32'(rd_data), 32'(i));
            step(0, 16'h0, 1, 0, "tp2_rd");
        end
        step(0, 16'h0, 0, 1, "tp2_flush");

        for (int i = 0; i < 5; i++) step(1, 16'(16'h0500 + i), 0, 0, "tp3_wa");
        for (int i = 0; i < 5; i++) step(0, 16'h0, 1, 0, "tp3_ra");
        for (int i = 0; i < 6; i++) step(1, 16'(16'h1000 + i), 0, 0, "tp3_wb");
        chk("tp3_count6", 32'(count), 32'h6);
        for (int i = 0; i < 6; i++) begin
            chk("tp3_order", 32'(rd_data), 32'(16'h1000 + i));
            step(0, 16'h0, 1, 0, "tp3_rb");
        end
        chk("tp3_count0", 32'(count), 32'h0);

        for (int i = 0; i < 8; i++) step(1, 16'(16'h0020 + i), 0, 0, "tp4_fill");
        step(1, 16'hBEEF, 1, 0, "tp4_both");
        chk("tp4_count", 32'(count), 32'h8);
        chk("tp4_ovf", 32'(overflow), 32'h0);
        chk("tp4_head", 32'(rd_data), 32'h0021);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("tp4_last", 32'(rd_data), 32'hBEEF);
            step(0, 16'h0, 1, 0, "tp4_rd");
        end

        step(0, 16'h0, 1, 0, "tp5_udf");
        chk("tp5_udf", 32'(underflow), 32'h1);
        step(1, 16'h5555, 0, 1, "tp5_flush");
        chk("tp5_clr", 32'(underflow), 32'h0);
        chk("tp5_empty", 32'(empty), 32'h1);

        for (int i = 0; i < 3; i++) step(1, 16'(16'h0300 + i), 0, 0, "tp6_wr");
        @(negedge clk);
        #2 reset_b = 1'b0;
        #1;
        q.delete(); m_ovf = 0; m_udf = 0;
        check_all("tp6_async");
        chk("tp6_count", 32'(count), 32'h0);
        @(negedge clk) reset_b = 1'b1;
        step(1, 16'h7777, 0, 0, "tp6_new");
        chk("tp6_data", 32'(rd_data), 32'h7777);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 6, 16'($urandom), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 63) == 0, "rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
